// File: rtl/gray_rx_decoder.sv
// Gray-coded counter receiver: decodes to binary, classifies each move and accumulates position.
// Define GRAY_RX_SYNC_EN to place a two-flop synchronizer in front of the sample register.
module gray_rx_decoder #(
   parameter int WIDTH = 4,
   parameter int POS_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] g_in,
   input  logic             clr_err,
   input  logic             pos_clr,
   output logic [WIDTH-1:0] b_out,
   output logic             step_up,
   output logic             step_down,
   output logic             wrap_up,
   output logic             wrap_down,
   output logic             err,
   output logic [7:0]       err_cnt,
   output logic [POS_W-1:0] pos
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] BIN_MAX = '1;
   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [3:0] popcount(input logic [WIDTH-1:0] v);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + 4'(v[i]);
      end
      return cnt;
   endfunction

   state_t           state_q;
   logic [WIDTH-1:0] g_s_q;
   logic [WIDTH-1:0] g_prev_q;
   logic [WIDTH-1:0] prev_bin_q;

   logic [WIDTH-1:0] bin_s;
   logic [WIDTH-1:0] bin_inc_s;
   logic [WIDTH-1:0] bin_dec_s;
   logic [3:0]       dist_s;
   logic             in_track_s;
   logic             move_up_s;
   logic             move_dn_s;
   logic             illegal_s;
   logic [POS_W-1:0] pos_d;
   logic [7:0]       err_cnt_d;

`ifdef GRAY_RX_SYNC_EN
   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;

   // Two-flop synchronizer ahead of the sample register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         g_s_q   <= '0;
      end else begin
         sync1_q <= g_in;
         sync2_q <= sync1_q;
         g_s_q   <= sync2_q;
      end
   end
`else
   // Sample register loads the gray input directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         g_s_q <= '0;
      end else begin
         g_s_q <= g_in;
      end
   end
`endif

   // A single-bit change that is not an adjacent count (e.g. 0 -> mid-scale) is treated as illegal.
   always_comb begin
      bin_s      = gray2bin(g_s_q);
      bin_inc_s  = prev_bin_q + BIN_ONE;
      bin_dec_s  = prev_bin_q - BIN_ONE;
      dist_s     = popcount(g_s_q ^ g_prev_q);
      in_track_s = (state_q == ST_TRACK);
      move_up_s  = in_track_s && (dist_s == 4'd1) && (bin_s == bin_inc_s);
      move_dn_s  = in_track_s && (dist_s == 4'd1) && (bin_s == bin_dec_s);
      illegal_s  = in_track_s && (dist_s != 4'd0) && !move_up_s && !move_dn_s;

      if (pos_clr) begin
         pos_d = '0;
      end else if (move_up_s) begin
         pos_d = pos + POS_ONE;
      end else if (move_dn_s) begin
         pos_d = pos - POS_ONE;
      end else begin
         pos_d = pos;
      end

      if (illegal_s && (err_cnt != 8'hFF)) begin
         err_cnt_d = err_cnt + 8'd1;
      end else begin
         err_cnt_d = err_cnt;
      end
   end

   // Tracking FSM with registered decode, pulse, error and position outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         g_prev_q   <= '0;
         prev_bin_q <= '0;
         b_out      <= '0;
         step_up    <= 1'b0;
         step_down  <= 1'b0;
         wrap_up    <= 1'b0;
         wrap_down  <= 1'b0;
         err        <= 1'b0;
         err_cnt    <= 8'd0;
         pos        <= '0;
      end else begin
         b_out     <= bin_s;
         step_up   <= move_up_s;
         step_down <= move_dn_s;
         wrap_up   <= move_up_s && (prev_bin_q == BIN_MAX);
         wrap_down <= move_dn_s && (prev_bin_q == '0);
         err_cnt   <= err_cnt_d;
         pos       <= pos_d;
         case (state_q)
            ST_INIT: begin
               g_prev_q   <= g_s_q;
               prev_bin_q <= bin_s;
               err        <= 1'b0;
               state_q    <= ST_TRACK;
            end
            ST_TRACK: begin
               g_prev_q   <= g_s_q;
               prev_bin_q <= bin_s;
               if (illegal_s) begin
                  err     <= 1'b1;
                  state_q <= ST_ERROR;
               end else begin
                  err     <= 1'b0;
                  state_q <= ST_TRACK;
               end
            end
            ST_ERROR: begin
               if (clr_err) begin
                  err     <= 1'b0;
                  state_q <= ST_INIT;
               end else begin
                  err     <= 1'b1;
                  state_q <= ST_ERROR;
               end
            end
            default: begin
               err     <= 1'b0;
               state_q <= ST_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed, table-driven bench for gray_rx_decoder (default WIDTH=4, POS_W=16).
// Each table row is applied before an edge; its expected outputs are those seen just after that edge.
module tb_gray_rx_decoder;

   logic        clk;
   logic        rst;
   logic [3:0]  g_in;
   logic        clr_err;
   logic        pos_clr;
   logic [3:0]  b_out;
   logic        step_up;
   logic        step_down;
   logic        wrap_up;
   logic        wrap_down;
   logic        err;
   logic [7:0]  err_cnt;
   logic [15:0] pos;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef GRAY_RX_SYNC_EN
   localparam int LAT_EDGES = 4;
`else
   localparam int LAT_EDGES = 2;
`endif

   typedef struct {
      logic [3:0]  g;
      logic        clr;
      logic        pclr;
      logic [3:0]  b;
      logic [3:0]  pulses;   // {step_up, step_down, wrap_up, wrap_down}
      logic        er;
      logic [7:0]  cnt;
      logic [15:0] pos;
   } vec_t;

   vec_t vecs[$];

   gray_rx_decoder #(.WIDTH(4), .POS_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .g_in      (g_in),
      .clr_err   (clr_err),
      .pos_clr   (pos_clr),
      .b_out     (b_out),
      .step_up   (step_up),
      .step_down (step_down),
      .wrap_up   (wrap_up),
      .wrap_down (wrap_down),
      .err       (err),
      .err_cnt   (err_cnt),
      .pos       (pos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] model_g2b(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      b[2] = b[3] ^ g[2];
      b[1] = b[2] ^ g[1];
      b[0] = b[1] ^ g[0];
      return b;
   endfunction

   function automatic logic [32:0] outs();
      return {b_out, step_up, step_down, wrap_up, wrap_down, err, err_cnt, pos};
   endfunction

   function automatic vec_t mk(input logic [3:0] g, input logic clr, input logic pclr,
                               input logic [3:0] b, input logic [3:0] pulses, input logic er,
                               input logic [7:0] cnt, input logic [15:0] p);
      vec_t v;
      v.g = g; v.clr = clr; v.pclr = pclr; v.b = b;
      v.pulses = pulses; v.er = er; v.cnt = cnt; v.pos = p;
      return v;
   endfunction

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [3:0] exp_b;
      int         seen;
      logic       up_at;

      //             g     clr   pclr  b     pulses   err   cnt    pos
      vecs.push_back(mk(4'h0, 1'b0, 1'b0, 4'd0,  4'b0000, 1'b0, 8'd0, 16'h0000));
      vecs.push_back(mk(4'h0, 1'b0, 1'b0, 4'd0,  4'b0000, 1'b0, 8'd0, 16'h0000));
      vecs.push_back(mk(4'h1, 1'b0, 1'b0, 4'd0,  4'b0000, 1'b0, 8'd0, 16'h0000));
      vecs.push_back(mk(4'h3, 1'b0, 1'b0, 4'd1,  4'b1000, 1'b0, 8'd0, 16'h0001));
      vecs.push_back(mk(4'h2, 1'b0, 1'b0, 4'd2,  4'b1000, 1'b0, 8'd0, 16'h0002));
      vecs.push_back(mk(4'h2, 1'b0, 1'b0, 4'd3,  4'b1000, 1'b0, 8'd0, 16'h0003));
      vecs.push_back(mk(4'h3, 1'b0, 1'b0, 4'd3,  4'b0000, 1'b0, 8'd0, 16'h0003));
      vecs.push_back(mk(4'h1, 1'b0, 1'b0, 4'd2,  4'b0100, 1'b0, 8'd0, 16'h0002));
      vecs.push_back(mk(4'h0, 1'b0, 1'b0, 4'd1,  4'b0100, 1'b0, 8'd0, 16'h0001));
      vecs.push_back(mk(4'h8, 1'b0, 1'b0, 4'd0,  4'b0100, 1'b0, 8'd0, 16'h0000));
      vecs.push_back(mk(4'h0, 1'b0, 1'b0, 4'd15, 4'b0101, 1'b0, 8'd0, 16'hFFFF));
      vecs.push_back(mk(4'h0, 1'b0, 1'b0, 4'd0,  4'b1010, 1'b0, 8'd0, 16'h0000));
      vecs.push_back(mk(4'h1, 1'b0, 1'b0, 4'd0,  4'b0000, 1'b0, 8'd0, 16'h0000));
      vecs.push_back(mk(4'h1, 1'b0, 1'b1, 4'd1,  4'b1000, 1'b0, 8'd0, 16'h0000));
      vecs.push_back(mk(4'h3, 1'b0, 1'b0, 4'd1,  4'b0000, 1'b0, 8'd0, 16'h0000));
      vecs.push_back(mk(4'h6, 1'b0, 1'b0, 4'd2,  4'b1000, 1'b0, 8'd0, 16'h0001));
      vecs.push_back(mk(4'h6, 1'b0, 1'b0, 4'd4,  4'b0000, 1'b1, 8'd1, 16'h0001));
      vecs.push_back(mk(4'h7, 1'b0, 1'b0, 4'd4,  4'b0000, 1'b1, 8'd1, 16'h0001));
      vecs.push_back(mk(4'h5, 1'b0, 1'b0, 4'd5,  4'b0000, 1'b1, 8'd1, 16'h0001));
      vecs.push_back(mk(4'h5, 1'b1, 1'b0, 4'd6,  4'b0000, 1'b0, 8'd1, 16'h0001));
      vecs.push_back(mk(4'h4, 1'b0, 1'b0, 4'd6,  4'b0000, 1'b0, 8'd1, 16'h0001));
      vecs.push_back(mk(4'h4, 1'b0, 1'b0, 4'd7,  4'b1000, 1'b0, 8'd1, 16'h0002));
      vecs.push_back(mk(4'hC, 1'b0, 1'b0, 4'd7,  4'b0000, 1'b0, 8'd1, 16'h0002));
      vecs.push_back(mk(4'hC, 1'b1, 1'b0, 4'd8,  4'b1000, 1'b0, 8'd1, 16'h0003));
      vecs.push_back(mk(4'hC, 1'b0, 1'b0, 4'd8,  4'b0000, 1'b0, 8'd1, 16'h0003));

      rst = 1'b1; g_in = 4'h0; clr_err = 1'b0; pos_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", outs(), 33'd0);
      rst = 1'b0;

`ifndef GRAY_RX_SYNC_EN
      for (int i = 0; i < vecs.size(); i++) begin
         g_in    = vecs[i].g;
         clr_err = vecs[i].clr;
         pos_clr = vecs[i].pclr;
         @(posedge clk);
         #1;
         check($sformatf("row%0d", i), outs(),
               {vecs[i].b, vecs[i].pulses, vecs[i].er, vecs[i].cnt, vecs[i].pos});
      end
`endif
      clr_err = 1'b0;
      pos_clr = 1'b0;
      repeat (6) @(posedge clk);
      #1;

      // Single +1 gray change: count edges until the decoded value appears.
      exp_b = model_g2b(g_in ^ 4'b0001);
      g_in  = g_in ^ 4'b0001;
      seen  = 0;
      up_at = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk);
         #1;
         if (seen == 0 && b_out == exp_b) begin
            seen  = n;
            up_at = step_up;
         end
      end
      check("latency_edges", 33'(seen), 33'(LAT_EDGES));
      check("latency_step_up", {32'd0, up_at}, 33'd1);

      // Reset mid-operation overrides clr_err/pos_clr and discards the in-flight sample.
      rst = 1'b1; clr_err = 1'b1; pos_clr = 1'b1; g_in = 4'h5;
      @(posedge clk);
      #1;
      check("mid_reset", outs(), 33'd0);
      rst = 1'b0; clr_err = 1'b0; pos_clr = 1'b0; g_in = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      check("post_reset_idle", outs(), 33'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_rx_decoder.md
GRAY_RX_DECODER -- requirements
Module: gray_rx_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: gray input and decoded binary width (2..8).
REQ-002 The block SHALL have parameter POS_W, default 16: position accumulator width.
REQ-003 Clocking SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk SHALL be an input, 1 bit: sole clock, rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: synchronous active-high reset.
REQ-006 Port g_in SHALL be an input, WIDTH bits: gray-coded count from a gray counter.
REQ-007 Port clr_err SHALL be an input, 1 bit: single-cycle pulse that leaves ERROR state.
REQ-008 Port pos_clr SHALL be an input, 1 bit: zeroes the position accumulator.
REQ-009 Port b_out SHALL be an output reg, WIDTH bits: registered binary decode of the sampled gray value.
REQ-010 Port step_up and port step_down SHALL be output regs, 1 bit each: single-cycle pulses for +1 and -1 moves.
REQ-011 Port wrap_up and port wrap_down SHALL be output regs, 1 bit each: pulses for max->0 and 0->max moves.
REQ-012 Port err SHALL be an output reg, 1 bit: high while in ERROR state.
REQ-013 Port err_cnt SHALL be an output reg, 8 bits: illegal-transition count.
REQ-014 Port pos SHALL be an output reg, POS_W bits: two's-complement accumulated position.

Function
REQ-015 Sampling SHALL use register g_s, loaded from the input path every cycle.
REQ-016 The decode SHALL be bin[WIDTH-1]=g_s[WIDTH-1]; bin[i]=bin[i+1]^g_s[i]; b_out SHALL be registered from bin every cycle, in all states.
REQ-017 Latency SHALL be as follows: a g_in change before edge N appears on b_out and the pulse outputs after edge N+1 (no sync), or after edge N+3 (sync enabled).
REQ-018 The FSM SHALL have states INIT, TRACK and ERROR, with registers g_prev and prev_bin.
REQ-019 In INIT, the block SHALL capture g_prev/prev_bin from g_s, emit no pulses, and go to TRACK on the next cycle.
REQ-020 In TRACK with g_s==g_prev, the block SHALL emit no pulses.
REQ-021 In TRACK with Hamming distance 1 and bin==prev_bin+1 mod 2^WIDTH, the block SHALL pulse step_up and increment pos; it SHALL also pulse wrap_up if prev_bin==2^WIDTH-1.
REQ-022 In TRACK with Hamming distance 1 and bin==prev_bin-1 mod 2^WIDTH, the block SHALL pulse step_down and decrement pos; it SHALL also pulse wrap_down if prev_bin==0.
REQ-023 In TRACK with Hamming distance >=2, the block SHALL emit no step pulse, leave pos unchanged, increment err_cnt (saturating at 255), and go to ERROR.
REQ-024 In TRACK, g_prev/prev_bin SHALL update to the current sample on every cycle.
REQ-025 In ERROR, err SHALL be 1, no pulses or pos changes SHALL occur, and err_cnt SHALL not change further; clr_err SHALL move the FSM to INIT (re-prime), and err SHALL drop on the same edge.
REQ-026 clr_err outside ERROR SHALL have no effect.
REQ-027 pos SHALL wrap modulo 2^POS_W without saturation.
REQ-028 pos_clr SHALL set pos to 0; when pos_clr coincides with a step, the clear SHALL win.
REQ-029 step_up, step_down, wrap_up and wrap_down SHALL never be asserted for more than one cycle per transition, and step_up and step_down SHALL never be asserted together.

Reset
REQ-030 rst SHALL force state INIT, g_s=0, sync flops=0, g_prev=0, prev_bin=0, b_out=0, all pulses=0, err=0, err_cnt=0, pos=0.
REQ-031 rst SHALL override clr_err and pos_clr; rst mid-operation SHALL discard in-flight samples.

Configuration
REQ-032 The macro GRAY_RX_SYNC_EN SHALL control the input synchronizer.
REQ-033 With GRAY_RX_SYNC_EN defined, g_in SHALL pass through a two-flop synchronizer before g_s, adding 2 cycles of latency.
REQ-034 Without GRAY_RX_SYNC_EN, g_s SHALL load g_in directly, and the function SHALL be otherwise identical.

Verification
REQ-035 Scenario: rst high 3 cycles, then g_in held 0000 -> b_out=0, no pulses, err=0, pos=0.
REQ-036 Scenario: g_in up-sequence 0000,0001,0011,0010 one per cycle -> b_out 0,1,2,3; three step_up pulses; pos=3.
REQ-037 Scenario: from binary 15 (gray 1000) to 0000 -> step_up and wrap_up in the same cycle; reverse direction -> step_down and wrap_down; pos returns to its prior value.
REQ-038 Scenario: from 0011 jump to 0110 -> err=1, err_cnt=1, pos unchanged; further changes give no pulses; clr_err -> INIT, next valid step counts.
REQ-039 Scenario: pos_clr asserted in the same cycle as a step_up -> pos=0 next cycle.
REQ-040 Scenario: with GRAY_RX_SYNC_EN, a single g_in change -> b_out updates exactly 2 cycles later than in the no-sync build.
